nlfsr_checker: RTL and testbench

Receive-side checker for the 4-bit NLFSR random stream. The block samples the generator's 4-bit output word and predicts each next word with the generator's update rule. It locks after a run of correct predictions, then flags and counts every mismatch. It sits downstream of the generator, at the consumer end of the RNG data path, and reports link and generator health.

---
 rtl/nlfsr_checker.sv | 162 ++++++++++++++++
 tb/tb_nlfsr_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/nlfsr_checker.sv
// Receive-side checker for a 4-bit NLFSR stream: syncs, locks, then flywheels and counts mispredictions.
// Optional all-zero stream detection is enabled with `define NLFSR_CHK_STUCK_EN.
module nlfsr_checker #(
    parameter int LOCK_LEN  = 4,
    parameter int LOSS_LEN  = 3,
    parameter int CNT_W     = 8,
    parameter int STUCK_LEN = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] good_count,
    output logic             stuck
);

    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam int LW = $clog2(LOSS_LEN + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_LEN);
    localparam logic [LW-1:0] LOSS_V = LW'(LOSS_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SYNC   = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_locked;
    logic             r_err;
    logic [3:0]       r_prev;
    logic [MW-1:0]    r_match_run;
    logic [LW-1:0]    r_miss_run;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_good_count;

    logic [3:0]       w_pred;
    logic             w_match;
    logic [MW-1:0]    w_match_nxt;
    logic [LW-1:0]    w_miss_nxt;
    logic             w_stuck_nxt;

    function automatic logic [3:0] pred(input logic [3:0] p);
        return {p[2:0], p[3] ^ (p[2] & p[1])};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_pred      = pred(r_prev);
    assign w_match     = (in_data == w_pred);
    // Saturate the run so a stuck-blocked lock attempt cannot wrap it.
    assign w_match_nxt = (r_match_run == LOCK_V) ? LOCK_V : r_match_run + MW'(1);
    assign w_miss_nxt  = r_miss_run + LW'(1);

`ifdef NLFSR_CHK_STUCK_EN
    localparam int ZW = $clog2(STUCK_LEN + 1);
    localparam logic [ZW-1:0] STUCK_V = ZW'(STUCK_LEN);

    logic [ZW-1:0] r_zero_run;
    logic          r_stuck;
    logic [ZW-1:0] w_zero_nxt;

    assign w_zero_nxt  = (r_zero_run == STUCK_V) ? STUCK_V : r_zero_run + ZW'(1);
    assign w_stuck_nxt = r_stuck | (in_valid && (in_data == 4'd0) && (w_zero_nxt == STUCK_V));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero_run <= '0;
            r_stuck    <= 1'b0;
        end else if (in_valid) begin
            r_zero_run <= (in_data == 4'd0) ? w_zero_nxt : '0;
            r_stuck    <= w_stuck_nxt;
        end
    end

    assign stuck = r_stuck;
`else
    logic w_unused_stuck_len;

    assign w_unused_stuck_len = (STUCK_LEN > 0);
    assign w_stuck_nxt        = 1'b0;
    assign stuck              = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_locked     <= 1'b0;
            r_err        <= 1'b0;
            r_prev       <= '0;
            r_match_run  <= '0;
            r_miss_run   <= '0;
            r_err_count  <= '0;
            r_good_count <= '0;
        end else begin
            r_err <= 1'b0;
            if (in_valid) begin
                unique case (r_state)
                    S_IDLE: begin
                        r_prev      <= in_data;
                        r_match_run <= '0;
                        r_state     <= S_SYNC;
                    end
                    S_SYNC: begin
                        r_prev <= in_data;
                        if (w_match) begin
                            r_match_run <= w_match_nxt;
                            if (w_match_nxt == LOCK_V && !w_stuck_nxt) begin
                                r_state    <= S_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_run <= '0;
                            end
                        end else begin
                            r_match_run <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (w_match) begin
                            r_prev       <= in_data;
                            r_miss_run   <= '0;
                            r_good_count <= sat_inc(r_good_count);
                        end else begin
                            // Flywheel: advance on our own prediction so one bad word costs one error.
                            r_err       <= 1'b1;
                            r_err_count <= sat_inc(r_err_count);
                            r_miss_run  <= w_miss_nxt;
                            if (w_miss_nxt == LOSS_V) begin
                                r_state     <= S_SYNC;
                                r_locked    <= 1'b0;
                                r_prev      <= in_data;
                                r_match_run <= '0;
                            end else begin
                                r_prev <= w_pred;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
                // A stuck stream overrides lock; later assignments take precedence.
                if (w_stuck_nxt && r_state == S_LOCKED) begin
                    r_state     <= S_SYNC;
                    r_locked    <= 1'b0;
                    r_prev      <= in_data;
                    r_match_run <= '0;
                end
            end
        end
    end

    assign locked     = r_locked;
    assign state      = r_state;
    assign err        = r_err;
    assign err_count  = r_err_count;
    assign good_count = r_good_count;

endmodule

// File: tb/tb_nlfsr_checker.sv
// Directed self-checking bench for nlfsr_checker (default parameters).
module tb_nlfsr_checker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       locked;
    logic [1:0] state;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] good_count;
    logic       stuck;

    int checks   = 0;
    int failures = 0;

    nlfsr_checker dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .state      (state),
        .err        (err),
        .err_count  (err_count),
        .good_count (good_count),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_pred(input logic [3:0] p);
        return {p[2:0], p[3] ^ (p[2] & p[1])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [3:0] p;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_goodcnt", good_count, 0);
        chk("rst_stuck", stuck, 0);
        reset = 1'b0;

        // Lock on 1,2,4,8,1
        step(1, 4'h1); chk("s1_state", state, 1);
        step(1, 4'h2);
        step(1, 4'h4);
        step(1, 4'h8); chk("s4_locked", locked, 0); chk("s4_state", state, 1);
        step(1, 4'h1); chk("s5_locked", locked, 1); chk("s5_state", state, 2);
        chk("s5_errcnt", err_count, 0);
        step(1, 4'h2); chk("g1_good", good_count, 1);
        step(1, 4'h4); chk("g2_good", good_count, 2); chk("g2_err", err, 0);

        // Three consecutive wrong words while locked (predicted 8,1,2)
        step(1, 4'h5); chk("m1_err", err, 1); chk("m1_cnt", err_count, 1); chk("m1_locked", locked, 1);
        step(1, 4'h5); chk("m2_err", err, 1); chk("m2_cnt", err_count, 2); chk("m2_locked", locked, 1);
        step(1, 4'h5); chk("m3_err", err, 1); chk("m3_cnt", err_count, 3);
        chk("m3_locked", locked, 0); chk("m3_state", state, 1); chk("m3_good", good_count, 2);
        step(0, 4'h5); chk("m_after_err", err, 0);

        // Flywheel over one corrupted word
        do_reset();
        step(1, 4'h6); step(1, 4'hD); step(1, 4'hB); step(1, 4'h7);
        step(1, 4'hF); chk("f_locked", locked, 1);
        step(1, 4'hE); chk("f_E_err", err, 0); chk("f_E_good", good_count, 1);
        step(1, 4'h0); chk("f_0_err", err, 1); chk("f_0_cnt", err_count, 1); chk("f_0_locked", locked, 1);
        step(1, 4'h9); chk("f_9_err", err, 0); chk("f_9_good", good_count, 2);
        step(1, 4'h3); chk("f_3_err", err, 0);
        step(1, 4'h6); chk("f_6_err", err, 0); chk("f_6_cnt", err_count, 1);
        chk("f_6_good", good_count, 4); chk("f_6_locked", locked, 1);

        // Gaps with in_valid low: nothing moves
        for (int i = 0; i < 10; i++) begin
            step(0, 4'hA);
            chk("gap1_err", err, 0);
            chk("gap1_state", state, 2);
        end
        step(1, 4'hD); chk("gap_D_err", err, 0); chk("gap_D_good", good_count, 5);
        for (int i = 0; i < 10; i++) begin
            step(0, 4'h0);
            chk("gap2_err", err, 0);
        end
        chk("gap2_good", good_count, 5);
        step(1, 4'hB); chk("gap_B_good", good_count, 6); chk("gap_B_locked", locked, 1);

        // Reset coincident with a mismatching valid sample
        reset = 1'b1;
        step(1, 4'h0);
        reset = 1'b0;
        chk("rl_state", state, 0); chk("rl_err", err, 0); chk("rl_locked", locked, 0);
        chk("rl_errcnt", err_count, 0); chk("rl_good", good_count, 0);
        step(0, 4'h0); chk("rl_err2", err, 0); chk("rl_state2", state, 0);

        // All-zero stream
        for (int i = 0; i < 8; i++) step(1, 4'h0);
`ifdef NLFSR_CHK_STUCK_EN
        chk("z_stuck", stuck, 1); chk("z_locked", locked, 0); chk("z_state", state, 1);
`else
        chk("z_stuck", stuck, 0); chk("z_locked", locked, 1); chk("z_good", good_count, 3);
`endif

        // Counter saturation: alternate wrong/right words so lock is kept
        do_reset();
        step(1, 4'h1); step(1, 4'h2); step(1, 4'h4); step(1, 4'h8); step(1, 4'h1);
        chk("sat_locked0", locked, 1);
        p = 4'h1;
        for (int i = 0; i < 260; i++) begin
            step(1, model_pred(p) ^ 4'hF);
            p = model_pred(p);
            step(1, model_pred(p));
            p = model_pred(p);
        end
        chk("sat_errcnt", err_count, 8'hFF);
        chk("sat_good", good_count, 8'hFF);
        chk("sat_locked", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
